// File: rtl/lamp_fpu_issue_queue.sv
// lamp_fpu_issue_queue: command FIFO and issue sequencer in front of the LAMP FPU core.
// Buffers up to DEPTH commands and issues ADD/SUB one at a time using the core's
// single-cycle-opcode protocol. Other opcodes are answered locally with a qNaN error
// response. Results are returned under a valid/ready handshake carrying a user tag.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  drop queued and in-flight work
//   cmd_*                    upstream command channel (valid/ready)
//   fpu_*                    core-side opcode/operands/padv/flush and result inputs
//   rsp_*                    downstream response channel (valid/ready)
//   busy_o                   work queued, in progress, or response pending

package lamp_fpu_issue_queue_pkg;
   localparam int unsigned LAMP_FLOAT_DW = 16;
   localparam int unsigned OPCODE_W      = 4;
   localparam int unsigned RNDMODE_W     = 3;

   typedef logic [OPCODE_W-1:0]  opcodeFPU_t;
   typedef logic [RNDMODE_W-1:0] rndModeFPU_t;

   localparam opcodeFPU_t  FPU_IDLE = 4'd0;
   localparam opcodeFPU_t  FPU_ADD  = 4'd1;
   localparam opcodeFPU_t  FPU_SUB  = 4'd2;
   localparam opcodeFPU_t  FPU_MUL  = 4'd3;
   localparam rndModeFPU_t FPU_RNDMODE_NEAREST = 3'd0;

   localparam logic [LAMP_FLOAT_DW-1:0] LAMP_QNAN = 16'h7FC0;

   // Operation payload of one queued command
   typedef struct packed {
      opcodeFPU_t                opcode;
      rndModeFPU_t               rnd_mode;
      logic [LAMP_FLOAT_DW-1:0]  op1;
      logic [LAMP_FLOAT_DW-1:0]  op2;
   } fpu_cmd_t;
endpackage

module lamp_fpu_issue_queue
   import lamp_fpu_issue_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush_i,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic [OPCODE_W-1:0]       cmd_opcode_i,
   input  logic [RNDMODE_W-1:0]      cmd_rndMode_i,
   input  logic [LAMP_FLOAT_DW-1:0]  cmd_op1_i,
   input  logic [LAMP_FLOAT_DW-1:0]  cmd_op2_i,
   input  logic [TAG_W-1:0]          cmd_tag_i,
   output logic [OPCODE_W-1:0]       fpu_opcode_o,
   output logic [RNDMODE_W-1:0]      fpu_rndMode_o,
   output logic [LAMP_FLOAT_DW-1:0]  fpu_op1_o,
   output logic [LAMP_FLOAT_DW-1:0]  fpu_op2_o,
   output logic                      fpu_padv_o,
   output logic                      fpu_flush_o,
   input  logic [LAMP_FLOAT_DW-1:0]  fpu_result_i,
   input  logic                      fpu_isResultValid_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [LAMP_FLOAT_DW-1:0]  rsp_result_o,
   output logic [TAG_W-1:0]          rsp_tag_o,
   output logic                      rsp_err_o,
   output logic                      busy_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

   fpu_cmd_t                  fifo_cmd [DEPTH];
   logic [TAG_W-1:0]          fifo_tag [DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [CNT_W-1:0]          count;

   state_t                    state, state_nxt;
   logic                      discard, discard_nxt;
   logic                      rej_pend;
   logic [RNDMODE_W-1:0]      iss_rnd;
   logic [LAMP_FLOAT_DW-1:0]  iss_op1, iss_op2;
   logic [TAG_W-1:0]          iss_tag;

   fpu_cmd_t                  head;
   logic                      head_supported;
   logic                      push, pop;
   logic                      load_core, load_rej;
   logic [OPCODE_W-1:0]       opcode_nxt;
   logic                      padv_nxt;

   // Upstream handshake; flush and reset both refuse new commands
   assign cmd_ready_o = (count < CNT_W'(DEPTH)) && !flush_i && !rst;
   assign push        = cmd_valid_i && cmd_ready_o;

   assign head           = fifo_cmd[rd_ptr];
   assign head_supported = (head.opcode == FPU_ADD) || (head.opcode == FPU_SUB);

   // Core must not start the op it is being shown this cycle
   assign fpu_flush_o = flush_i && (state == S_ISSUE) && !rst;

   // rej_pend covers the one cycle a filtered command spends between pop and response
   assign busy_o = (count != '0) || (state != S_IDLE) || rsp_valid_o || rej_pend;

   assign fpu_rndMode_o = iss_rnd;
   assign fpu_op1_o     = iss_op1;
   assign fpu_op2_o     = iss_op2;

   // Next state, pop decision and response load strobes
   always_comb begin
      state_nxt   = state;
      discard_nxt = discard;
      pop         = 1'b0;
      load_core   = 1'b0;
      load_rej    = rej_pend && !flush_i;
      case (state)
         S_IDLE: begin
            if ((count != '0) && !rsp_valid_o && !rej_pend && !flush_i) begin
               pop = 1'b1;
               if (head_supported) state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nxt = flush_i ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            // The core cannot abort: remember the flush and let the op finish
            if (flush_i) discard_nxt = 1'b1;
            if (fpu_isResultValid_i) begin
               state_nxt = S_ACK;
               load_core = !(discard || flush_i);
            end
         end
         S_ACK: begin
            state_nxt   = S_IDLE;
            discard_nxt = 1'b0;
         end
         default: state_nxt = S_IDLE;
      endcase
      opcode_nxt = (state_nxt == S_ISSUE) ? head.opcode : FPU_IDLE;
      padv_nxt   = (state_nxt == S_ACK);
   end

   // FIFO storage (no reset needed; validity tracked by count)
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_cmd[wr_ptr] <= '{opcode: cmd_opcode_i, rnd_mode: cmd_rndMode_i,
                               op1: cmd_op1_i, op2: cmd_op2_i};
         fifo_tag[wr_ptr] <= cmd_tag_i;
      end
   end

   // Control, issue register and response register
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         state        <= S_IDLE;
         discard      <= 1'b0;
         rej_pend     <= 1'b0;
         iss_rnd      <= FPU_RNDMODE_NEAREST;
         iss_op1      <= '0;
         iss_op2      <= '0;
         iss_tag      <= '0;
         fpu_opcode_o <= FPU_IDLE;
         fpu_padv_o   <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_result_o <= '0;
         rsp_tag_o    <= '0;
         rsp_err_o    <= 1'b0;
      end else begin
         state        <= state_nxt;
         discard      <= discard_nxt;
         fpu_opcode_o <= opcode_nxt;
         fpu_padv_o   <= padv_nxt;
         rej_pend     <= pop && !head_supported;

         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end

         if (pop) begin
            iss_rnd <= head.rnd_mode;
            iss_op1 <= head.op1;
            iss_op2 <= head.op2;
            iss_tag <= fifo_tag[rd_ptr];
         end

         if (flush_i) begin
            rsp_valid_o <= 1'b0;
         end else if (load_core) begin
            rsp_valid_o  <= 1'b1;
            rsp_result_o <= fpu_result_i;
            rsp_tag_o    <= iss_tag;
            rsp_err_o    <= 1'b0;
         end else if (load_rej) begin
            rsp_valid_o  <= 1'b1;
            rsp_result_o <= LAMP_QNAN;
            rsp_tag_o    <= iss_tag;
            rsp_err_o    <= 1'b1;
         end else if (rsp_valid_o && rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lamp_fpu_issue_queue.sv
// Bench for lamp_fpu_issue_queue: fixed-latency core stub, transaction-level
// expectation queues, and directed scenarios with literal expectations.
module tb_lamp_fpu_issue_queue;
   import lamp_fpu_issue_queue_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 4;
   localparam int unsigned LAT   = 4;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic                      flush_i = 1'b0;
   logic                      cmd_valid_i = 1'b0;
   logic                      cmd_ready_o;
   logic [OPCODE_W-1:0]       cmd_opcode_i = FPU_IDLE;
   logic [RNDMODE_W-1:0]      cmd_rndMode_i = FPU_RNDMODE_NEAREST;
   logic [LAMP_FLOAT_DW-1:0]  cmd_op1_i = '0;
   logic [LAMP_FLOAT_DW-1:0]  cmd_op2_i = '0;
   logic [TAG_W-1:0]          cmd_tag_i = '0;
   logic [OPCODE_W-1:0]       fpu_opcode_o;
   logic [RNDMODE_W-1:0]      fpu_rndMode_o;
   logic [LAMP_FLOAT_DW-1:0]  fpu_op1_o, fpu_op2_o;
   logic                      fpu_padv_o, fpu_flush_o;
   logic [LAMP_FLOAT_DW-1:0]  fpu_result_i;
   logic                      fpu_isResultValid_i;
   logic                      rsp_valid_o;
   logic                      rsp_ready_i = 1'b1;
   logic [LAMP_FLOAT_DW-1:0]  rsp_result_o;
   logic [TAG_W-1:0]          rsp_tag_o;
   logic                      rsp_err_o;
   logic                      busy_o;

   always #5 clk = ~clk;

   lamp_fpu_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_opcode_i(cmd_opcode_i), .cmd_rndMode_i(cmd_rndMode_i),
      .cmd_op1_i(cmd_op1_i), .cmd_op2_i(cmd_op2_i), .cmd_tag_i(cmd_tag_i),
      .fpu_opcode_o(fpu_opcode_o), .fpu_rndMode_o(fpu_rndMode_o),
      .fpu_op1_o(fpu_op1_o), .fpu_op2_o(fpu_op2_o),
      .fpu_padv_o(fpu_padv_o), .fpu_flush_o(fpu_flush_o),
      .fpu_result_i(fpu_result_i), .fpu_isResultValid_i(fpu_isResultValid_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o), .rsp_err_o(rsp_err_o),
      .busy_o(busy_o)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Core stub: only the bfloat16 cases this bench uses
   function automatic logic [15:0] core_calc(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
      if (op == FPU_ADD && a == 16'h3F80 && b == 16'h4000) return 16'h4040; // 1+2
      if (op == FPU_ADD && a == 16'h4000 && b == 16'h4000) return 16'h4080; // 2+2
      if (op == FPU_SUB && a == 16'h4040 && b == 16'h3F80) return 16'h4000; // 3-1
      return 16'hDEAD;
   endfunction

   int unsigned       core_cnt = 0;
   logic [15:0]       core_res = '0;
   always @(posedge clk) begin
      if (rst) core_cnt <= 0;
      else if ((fpu_opcode_o == FPU_ADD || fpu_opcode_o == FPU_SUB) && !fpu_flush_o) begin
         core_cnt <= LAT;
         core_res <= core_calc(fpu_opcode_o, fpu_op1_o, fpu_op2_o);
      end else if (core_cnt != 0) core_cnt <= core_cnt - 1;
   end
   assign fpu_isResultValid_i = (core_cnt == 1);
   assign fpu_result_i        = core_res;

   // Expected behaviour at transaction level
   typedef struct { logic [15:0] res; logic [TAG_W-1:0] tag; logic err; } rsp_t;
   typedef struct { logic [3:0] op; logic [15:0] a; logic [15:0] b; logic [2:0] rnd; } iss_t;
   rsp_t expq[$];
   iss_t issq[$];
   int   rsp_cnt = 0, issue_cnt = 0, padv_cnt = 0, pend_padv = 0;
   logic [15:0]      last_res = '0;
   logic [TAG_W-1:0] last_tag = '0;
   logic             last_err = 1'b0;
   logic             prev_hold = 1'b0, prev_issue = 1'b0;
   logic [31:0]      prev_rsp = '0;

   always @(negedge clk) begin
      rsp_t e;
      iss_t f;
      if (rst) begin
         expq.delete(); issq.delete();
         pend_padv = 0; prev_hold = 1'b0; prev_issue = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("rsp_hold_valid", 32'(rsp_valid_o), 1);
            chk("rsp_hold_data", 32'({rsp_result_o, rsp_tag_o, rsp_err_o}), prev_rsp);
         end
         if (rsp_valid_o && rsp_ready_i) begin
            chk("rsp_expected", 32'(expq.size() != 0), 1);
            if (expq.size() != 0) begin
               e = expq.pop_front();
               chk("rsp_result", 32'(rsp_result_o), 32'(e.res));
               chk("rsp_tag", 32'(rsp_tag_o), 32'(e.tag));
               chk("rsp_err", 32'(rsp_err_o), 32'(e.err));
            end
            rsp_cnt++;
            last_res = rsp_result_o; last_tag = rsp_tag_o; last_err = rsp_err_o;
         end
         prev_hold = rsp_valid_o && !rsp_ready_i;
         prev_rsp  = 32'({rsp_result_o, rsp_tag_o, rsp_err_o});

         if (fpu_opcode_o != FPU_IDLE) begin
            issue_cnt++;
            chk("issue_one_cycle", 32'(prev_issue), 0);
            chk("issue_rsp_slot_empty", 32'(rsp_valid_o), 0);
            chk("issue_expected", 32'(issq.size() != 0), 1);
            if (issq.size() != 0) begin
               f = issq.pop_front();
               chk("issue_opcode", 32'(fpu_opcode_o), 32'(f.op));
               chk("issue_op1", 32'(fpu_op1_o), 32'(f.a));
               chk("issue_op2", 32'(fpu_op2_o), 32'(f.b));
               chk("issue_rnd", 32'(fpu_rndMode_o), 32'(f.rnd));
            end
            if (!flush_i) pend_padv++;
         end
         prev_issue = (fpu_opcode_o != FPU_IDLE);
         chk("fpu_flush", 32'(fpu_flush_o), 32'(flush_i && fpu_opcode_o != FPU_IDLE));

         if (fpu_padv_o) begin
            padv_cnt++;
            chk("padv_expected", 32'(pend_padv > 0), 1);
            if (pend_padv > 0) pend_padv--;
         end

         // Command accepted at the coming edge
         if (cmd_valid_i && cmd_ready_o) begin
            if (cmd_opcode_i == FPU_ADD || cmd_opcode_i == FPU_SUB) begin
               expq.push_back('{core_calc(cmd_opcode_i, cmd_op1_i, cmd_op2_i), cmd_tag_i, 1'b0});
               issq.push_back('{cmd_opcode_i, cmd_op1_i, cmd_op2_i, cmd_rndMode_i});
            end else begin
               expq.push_back('{16'h7FC0, cmd_tag_i, 1'b1});
            end
         end
         if (flush_i) begin
            expq.delete(); issq.delete();
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic samp();
      @(negedge clk); #1;
   endtask

   task automatic push_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] rnd, input logic [TAG_W-1:0] tag);
      int n;
      cmd_valid_i = 1'b1; cmd_opcode_i = op; cmd_op1_i = a; cmd_op2_i = b;
      cmd_rndMode_i = rnd; cmd_tag_i = tag;
      n = 0;
      samp();
      while (!cmd_ready_o && n < 200) begin samp(); n++; end
      chk("push_ready", 32'(cmd_ready_o), 1);
      tick();
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      int n;
      n = 0;
      while (rsp_cnt < target && n < 300) begin tick(); n++; end
      chk("rsp_count_reached", 32'(rsp_cnt >= target), 1);
   endtask

   initial begin
      int r0, i0, p0, n;
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, i0, p0, n;
      tick(); tick();
      rst = 1'b0;
      samp();
      chk("reset_rsp_valid", 32'(rsp_valid_o), 0);
      chk("reset_rsp_result", 32'(rsp_result_o), 0);
      chk("reset_rsp_tag", 32'(rsp_tag_o), 0);
      chk("reset_rsp_err", 32'(rsp_err_o), 0);
      chk("reset_opcode", 32'(fpu_opcode_o), 32'(FPU_IDLE));
      chk("reset_rnd", 32'(fpu_rndMode_o), 32'(FPU_RNDMODE_NEAREST));
      chk("reset_op1", 32'(fpu_op1_o), 0);
      chk("reset_padv", 32'(fpu_padv_o), 0);
      chk("reset_busy", 32'(busy_o), 0);
      chk("reset_cmd_ready", 32'(cmd_ready_o), 1);
      tick();

      // Single ADD
      r0 = rsp_cnt; i0 = issue_cnt; p0 = padv_cnt;
      push_cmd(FPU_ADD, 16'h3F80, 16'h4000, 3'd2, 4'd3);
      wait_rsp(r0 + 1);
      repeat (3) tick();
      chk("add_issue_count", 32'(issue_cnt - i0), 1);
      chk("add_padv_count", 32'(padv_cnt - p0), 1);
      chk("add_result", 32'(last_res), 32'h4040);
      chk("add_tag", 32'(last_tag), 3);
      chk("add_err", 32'(last_err), 0);

      // Fill the FIFO with five SUBs
      r0 = rsp_cnt;
      for (int k = 0; k < 5; k++) push_cmd(FPU_SUB, 16'h4040, 16'h3F80, 3'd0, TAG_W'(k));
      samp();
      chk("full_ready_low", 32'(cmd_ready_o), 0);
      wait_rsp(r0 + 5);
      chk("fill_last_tag", 32'(last_tag), 4);
      chk("fill_last_result", 32'(last_res), 32'h4000);
      repeat (2) tick();

      // Filtered opcode answered locally at E0+2
      i0 = issue_cnt; r0 = rsp_cnt;
      push_cmd(FPU_MUL, 16'h4000, 16'h4000, 3'd0, 4'd7);
      samp(); chk("rej_valid_e0", 32'(rsp_valid_o), 0);
      samp(); chk("rej_valid_e1", 32'(rsp_valid_o), 0);
      samp();
      chk("rej_valid_e2", 32'(rsp_valid_o), 1);
      chk("rej_result", 32'(rsp_result_o), 32'h7FC0);
      chk("rej_tag", 32'(rsp_tag_o), 7);
      chk("rej_err", 32'(rsp_err_o), 1);
      repeat (3) tick();
      chk("rej_no_issue", 32'(issue_cnt - i0), 0);
      chk("rej_rsp_count", 32'(rsp_cnt - r0), 1);

      // Backpressure: second command waits for the response slot
      rsp_ready_i = 1'b0;
      r0 = rsp_cnt;
      push_cmd(FPU_ADD, 16'h3F80, 16'h4000, 3'd0, 4'd1);
      push_cmd(FPU_ADD, 16'h4000, 16'h4000, 3'd0, 4'd2);
      n = 0;
      while (!rsp_valid_o && n < 100) begin tick(); n++; end
      i0 = issue_cnt;
      repeat (10) tick();
      chk("bp_no_issue", 32'(issue_cnt - i0), 0);
      chk("bp_valid_held", 32'(rsp_valid_o), 1);
      chk("bp_result_held", 32'(rsp_result_o), 32'h4040);
      chk("bp_tag_held", 32'(rsp_tag_o), 1);
      rsp_ready_i = 1'b1;
      wait_rsp(r0 + 2);
      chk("bp_second_tag", 32'(last_tag), 2);
      chk("bp_second_result", 32'(last_res), 32'h4080);
      repeat (2) tick();

      // Flush during ISSUE
      r0 = rsp_cnt; i0 = issue_cnt; p0 = padv_cnt;
      push_cmd(FPU_ADD, 16'h3F80, 16'h4000, 3'd0, 4'd5);
      tick();
      flush_i = 1'b1;
      samp();
      chk("flush_issue_opcode", 32'(fpu_opcode_o), 32'(FPU_ADD));
      chk("flush_issue_fpu_flush", 32'(fpu_flush_o), 1);
      tick();
      flush_i = 1'b0;
      repeat (15) tick();
      chk("flush_issue_no_rsp", 32'(rsp_cnt - r0), 0);
      chk("flush_issue_no_padv", 32'(padv_cnt - p0), 0);
      chk("flush_issue_busy", 32'(busy_o), 0);

      // Flush during WAIT with a second command queued
      r0 = rsp_cnt; i0 = issue_cnt; p0 = padv_cnt;
      push_cmd(FPU_ADD, 16'h3F80, 16'h4000, 3'd0, 4'd8);
      push_cmd(FPU_ADD, 16'h4000, 16'h4000, 3'd0, 4'd9);
      tick();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      n = 0;
      while (padv_cnt == p0 && n < 100) begin tick(); n++; end
      chk("flush_wait_padv", 32'(padv_cnt - p0), 1);
      samp();
      chk("flush_wait_busy", 32'(busy_o), 0);
      chk("flush_wait_rsp_valid", 32'(rsp_valid_o), 0);
      repeat (10) tick();
      chk("flush_wait_no_rsp", 32'(rsp_cnt - r0), 0);
      chk("flush_wait_one_issue", 32'(issue_cnt - i0), 1);

      // Reset while in WAIT with three commands queued
      r0 = rsp_cnt; i0 = issue_cnt;
      for (int k = 0; k < 4; k++) push_cmd(FPU_ADD, 16'h3F80, 16'h4000, 3'd1, TAG_W'(10 + k));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      samp();
      chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
      chk("rst_rsp_result", 32'(rsp_result_o), 0);
      chk("rst_rsp_tag", 32'(rsp_tag_o), 0);
      chk("rst_opcode", 32'(fpu_opcode_o), 32'(FPU_IDLE));
      chk("rst_rnd", 32'(fpu_rndMode_o), 32'(FPU_RNDMODE_NEAREST));
      chk("rst_op1", 32'(fpu_op1_o), 0);
      chk("rst_op2", 32'(fpu_op2_o), 0);
      chk("rst_padv", 32'(fpu_padv_o), 0);
      chk("rst_flush", 32'(fpu_flush_o), 0);
      chk("rst_busy", 32'(busy_o), 0);
      chk("rst_cmd_ready", 32'(cmd_ready_o), 1);
      repeat (30) tick();
      chk("rst_no_rsp", 32'(rsp_cnt - r0), 0);
      chk("rst_one_issue", 32'(issue_cnt - i0), 1);
      chk("rst_idle_busy", 32'(busy_o), 0);

      chk("end_expq_empty", 32'(expq.size()), 0);
      chk("end_issq_empty", 32'(issq.size()), 0);
      chk("end_padv_balance", 32'(pend_padv), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
